// File: rtl/gpr_pkg.sv
// gpr_pkg: shared definitions for the general-purpose register read port.
//   - selector codes for the register bank slices (SEL_EDI = 4'h6)
//   - SEL_NONE: the value on the write interface meaning "no write this cycle"
//   - default sizing (NUM_REGS, DATA_W)
//   - read FSM state encoding
package gpr_pkg;

  localparam int NUM_REGS_DEF = 8;
  localparam int DATA_W_DEF   = 32;

  localparam logic [3:0] SEL_EAX  = 4'h0;
  localparam logic [3:0] SEL_EBX  = 4'h1;
  localparam logic [3:0] SEL_ECX  = 4'h2;
  localparam logic [3:0] SEL_EDX  = 4'h3;
  localparam logic [3:0] SEL_ESP  = 4'h4;
  localparam logic [3:0] SEL_ESI  = 4'h5;
  localparam logic [3:0] SEL_EDI  = 4'h6;
  localparam logic [3:0] SEL_EBP  = 4'h7;
  localparam logic [3:0] SEL_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ_A = 2'd1,
    ST_READ_B = 2'd2,
    ST_DONE   = 2'd3
  } gpr_state_e;

endpackage

// File: rtl/gpr_select.sv
// gpr_select: combinational selector for one register value.
//   sel           - selector code to read
//   reg_bank      - flattened register values, slice k = code k
//   read_or_write - selector currently driven on the write interface
//   write_data    - data on the write interface
//   value         - selected value (0 for an out-of-range selector)
//   err           - selector >= NUM_REGS
// A write in flight to the same register wins over the bank slice so the
// reader never observes the pre-write value.
module gpr_select
  import gpr_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic [3:0]                 sel,
  input  logic [NUM_REGS*DATA_W-1:0] reg_bank,
  input  logic [3:0]                 read_or_write,
  input  logic [DATA_W-1:0]          write_data,
  output logic [DATA_W-1:0]          value,
  output logic                       err
);

  always_comb begin
    value = '0;
    err   = 1'b1;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (sel == 4'(k)) begin
        err   = 1'b0;
        value = (read_or_write == sel) ? write_data
                                       : reg_bank[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/gpr_read_port.sv
// gpr_read_port: fetches one or two register values by selector code and
// presents them with a valid/ack handshake.
//   clock_4       - read-phase clock, all state on its rising edge
//   reset         - synchronous, active-low
//   reg_bank      - flattened register values, slice k = code k
//   read_or_write - write selector on the shared write interface (F = none)
//   write_data    - write interface data (forwarded on selector match)
//   rd_req        - read request, only sampled in IDLE
//   rd_sel_a/b    - operand selectors, latched on acceptance
//   two_op        - 1 = fetch A and B, 0 = A only
//   rd_ack        - consumer accepts results
//   operand_a/b   - captured operands (B is 0 for single-operand reads)
//   rd_valid      - results valid (high exactly while in DONE)
//   rd_err        - a selector was out of range (sticky until next accept)
//   busy          - not IDLE
module gpr_read_port
  import gpr_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                       clock_4,
  input  logic                       reset,
  input  logic [NUM_REGS*DATA_W-1:0] reg_bank,
  input  logic [3:0]                 read_or_write,
  input  logic [DATA_W-1:0]          write_data,
  input  logic                       rd_req,
  input  logic [3:0]                 rd_sel_a,
  input  logic [3:0]                 rd_sel_b,
  input  logic                       two_op,
  input  logic                       rd_ack,
  output logic [DATA_W-1:0]          operand_a,
  output logic [DATA_W-1:0]          operand_b,
  output logic                       rd_valid,
  output logic                       rd_err,
  output logic                       busy
);

  gpr_state_e        state;
  logic [3:0]        sel_a_q, sel_b_q;
  logic              two_op_q;
  logic [3:0]        cap_sel;
  logic [DATA_W-1:0] cap_value;
  logic              cap_err;

  // One selector shared by both captures; B only uses it in READ_B.
  assign cap_sel = (state == ST_READ_B) ? sel_b_q : sel_a_q;
  assign busy    = (state != ST_IDLE);

  gpr_select #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_sel (
    .sel           (cap_sel),
    .reg_bank      (reg_bank),
    .read_or_write (read_or_write),
    .write_data    (write_data),
    .value         (cap_value),
    .err           (cap_err)
  );

  always_ff @(posedge clock_4) begin
    if (!reset) begin
      state     <= ST_IDLE;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      two_op_q  <= 1'b0;
      operand_a <= '0;
      operand_b <= '0;
      rd_valid  <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_req) begin
            sel_a_q  <= rd_sel_a;
            sel_b_q  <= rd_sel_b;
            two_op_q <= two_op;
            rd_err   <= 1'b0;
            state    <= ST_READ_A;
          end
        end
        ST_READ_A: begin
          operand_a <= cap_value;
          if (cap_err) rd_err <= 1'b1;
          if (two_op_q) begin
            state <= ST_READ_B;
          end else begin
            operand_b <= '0;
            rd_valid  <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_READ_B: begin
          operand_b <= cap_value;
          if (cap_err) rd_err <= 1'b1;
          rd_valid  <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          // rd_req here is deliberately ignored; it must be re-presented in IDLE.
          if (rd_ack) begin
            rd_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
